instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end stage that feeds cpuControl/datapath: owns PC, fetches 16-bit Thumb-style instrs from a
//  variable-latency instruction memory, buffers them in a small queue, hands {PC,instr} to decode
//  under valid/ready. Applies redirects (brSel/brEx) from decode; kills stale in-flight fetches.
// PARAMETERS
//  QDEPTH    2       fetch-queue entries (power of 2, >=2)
//  RESET_PC  16'h0   PC loaded on reset
// PORTS
//  clk          in   1   clock; all state on posedge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   fetch request valid; held until imem_ack
//  imem_addr    out  16  instr address (one instr per address); stable while imem_req
//  imem_ack     in   1   response valid; one cycle per request, >=1 cycle after req accepted
//  imem_rdata   in   16  instruction, valid with imem_ack
//  instr_valid  out  1   queue head valid to decode
//  instr_ready  in   1   decode consumes head this cycle
//  instr        out  16  head instruction
//  PC           out  16  address of head instruction
//  redir_valid  in   1   decode resolved a control transfer for instr at redir_pc
//  redir_pc     in   16  PC of branch instr
//  redir_instr  in   16  branch instr (offset field source)
//  brSel        in   2   00 BL, 01 cond-taken, 10 B, 11 sequential (no redirect)
//  brEx         in   1   BX: target = brTarget (overrides brSel)
//  brTarget     in   16  register value for BX
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, PC=0, queue empty, fetch_pc=RESET_PC, FSM=S_IDLE.
//  FSM (cpu_pkg::fetch_state_t): S_IDLE->S_REQ next cycle after reset deasserts.
//   S_REQ: imem_req=1 when queue has a free slot counting the in-flight one; else imem_req=0, stay.
//     imem_ack -> push {fetch_pc,rdata}, fetch_pc+=1, stay S_REQ (back-to-back issue allowed same cycle).
//   Redirect while request outstanding and no ack this cycle -> S_DISCARD; fetch_pc=target.
//   S_DISCARD: imem_req=1 held on old address (no mid-request address change); on imem_ack drop data,
//     -> S_REQ issuing target next cycle.
//  Redirect taken when redir_valid & (brEx | brSel!=2'b11):
//   target: brEx -> brTarget; 01 -> redir_pc+1+sext(redir_instr[7:0]);
//   10/00 -> redir_pc+1+sext(redir_instr[10:0]); all mod 2^16 (wraps).
//   Same cycle: queue flushed (instr_valid=0 next cycle), head not consumed even if instr_ready=1.
//   Redirect + imem_ack same cycle: ack data dropped, FSM -> S_REQ at target (no discard needed).
//   redir_valid with brSel=11 & !brEx: no effect.
//  Queue: push on accepted ack, pop on instr_valid&instr_ready; simultaneous push/pop at full allowed.
//   Full (QDEPTH incl. in-flight) -> no new request; empty -> instr_valid=0. No combinational ready->req path.
//  Latency: reset release to first imem_req = 1 cycle; ack to instr_valid = 1 cycle.
//  fetch_pc wraps 16'hFFFF -> 16'h0000.
//  Reset mid-operation: all state returns to reset values next edge; pending ack ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles instr_valid=0 & !reset) and
//   perf_redir_cnt[31:0] (redirects taken), saturating, cleared by reset.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  cpu_pkg: br_sel_t enum {BR_LINK=2'b00, BR_COND=2'b01, BR_UNCOND=2'b10, BR_SEQ=2'b11},
//   fetch_state_t {S_IDLE,S_REQ,S_DISCARD}, sext8/sext11 functions.
//  Sub-module fetch_queue (param DEPTH, WIDTH=32): sync FIFO with flush, push, pop, full, empty, count.
// TESTING
//  1 reset 3 cycles, ack 1 cycle after each req, ready=1 -> imem_addr 0,1,2,...; PC/instr match in order.
//  2 req @5, redirect brSel=01 redir_pc=5 instr[7:0]=8'hFE before ack -> ack dropped, next addr 16'h0004.
//  3 instr_ready=0, QDEPTH=2 -> two acks queued, imem_req=0 until a pop; no instr lost/duplicated.
//  4 brEx=1 brTarget=16'h1234 same cycle as imem_ack -> data dropped, queue empty, next imem_addr 16'h1234.
//  5 B instr[10:0]=11'h7FF at redir_pc=16'h0000 -> target 16'h0000; fetch_pc 16'hFFFF -> next 16'h0000.
//  6 reset asserted during S_DISCARD -> all outputs reset values next cycle; late ack ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side types: branch-select encoding, fetch FSM states, offset sign-extension helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_LINK   = 2'b00,
    BR_COND   = 2'b01,
    BR_UNCOND = 2'b10,
    BR_SEQ    = 2'b11
  } br_sel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } fetch_state_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; push-to-head latency 1 cycle, push accepted at full only alongside a pop.
// Flush overrides push and pop in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC ownership, imem request FSM, redirect/kill, queued {PC,instr} to decode; ack->valid 1 cycle.
// Requests stop while the queue (counting the in-flight fetch) is full; FETCH_PERF_EN adds perf counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          QDEPTH   = 2,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] PC,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  input  logic [15:0] redir_instr,
  input  logic [1:0]  brSel,
  input  logic        brEx,
  input  logic [15:0] brTarget
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redir_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  addr_q, addr_d;
  br_sel_t      br_sel;
  logic         redir_take, ack_fire;
  logic [15:0]  redir_target;
  logic         q_push, q_pop, q_flush, q_full, q_empty;
  logic [31:0]  q_head;
  logic [CW-1:0] q_count;

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(32)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (q_flush),
    .push     (q_push),
    .push_dat ({fetch_pc_q, imem_rdata}),
    .pop      (q_pop),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign instr_valid = (q_count != '0);
  assign {PC, instr} = q_empty ? 32'h0 : q_head;
  assign imem_addr   = addr_q;

  always_comb begin
    br_sel       = br_sel_t'(brSel);
    redir_take   = redir_valid & (brEx | (br_sel != BR_SEQ));
    redir_target = redir_pc + 16'd1 + sext11(redir_instr[10:0]);
    if (brEx)                  redir_target = brTarget;
    else if (br_sel == BR_COND) redir_target = redir_pc + 16'd1 + sext8(redir_instr[7:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_REQ;
      S_REQ:     if (redir_take && imem_req && !imem_ack) state_d = S_DISCARD;
      S_DISCARD: if (imem_ack) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_REQ:     imem_req = ~q_full;
      S_DISCARD: imem_req = 1'b1;
      default:   imem_req = 1'b0;
    endcase
    ack_fire = imem_ack & imem_req;
    q_push   = ack_fire & (state_q == S_REQ) & ~redir_take;
    q_pop    = instr_valid & instr_ready & ~redir_take;
    q_flush  = redir_take;
  end

  // A discarding request keeps its original address until the stale ack returns.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redir_take)                           fetch_pc_d = redir_target;
    else if (ack_fire && state_q == S_REQ)    fetch_pc_d = fetch_pc_q + 16'd1;
    addr_d = (state_d == S_DISCARD) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (!instr_valid && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redir_take && redir_cnt_q != 32'hFFFF_FFFF)   redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order fetch, redirects with/without ack, backpressure, wrap, reset.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] PC;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic [15:0] redir_instr;
  logic [1:0]  brSel;
  logic        brEx;
  logic [15:0] brTarget;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.QDEPTH(2), .RESET_PC(16'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .PC          (PC),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_instr (redir_instr),
    .brSel       (brSel),
    .brEx        (brEx),
    .brTarget    (brTarget)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a pending request at addr a, wait one cycle, then return data d with a one-cycle ack.
  task automatic serve(input logic [15:0] a, input logic [15:0] d);
    chk("serve_req", {31'b0, imem_req}, 32'd1);
    chk("serve_addr", {16'b0, imem_addr}, {16'b0, a});
    tick();
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc, input logic [15:0] d);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, {16'b0, PC}, {16'b0, pc});
    chk({tag, "_instr"}, {16'b0, instr}, {16'b0, d});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, {16'b0, imem_addr}, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, {16'b0, instr}, 32'h0);
    chk({tag, "_pc"}, {16'b0, PC}, 32'h0);
  endtask

  task automatic clear_redir();
    redir_valid = 1'b0;
    brEx        = 1'b0;
    brSel       = 2'b11;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    redir_valid = 1'b0; redir_pc = '0; redir_instr = '0; brSel = 2'b11; brEx = 1'b0; brTarget = '0;

    // 1: reset, then in-order fetch with ready=1
    repeat (3) tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      serve(16'(i), 16'hA000 + 16'(i));
      chk_head("seq", 16'(i), 16'hA000 + 16'(i));
    end

    // 2: request at 5 killed by BR_COND redirect to 5+1-2 = 4
    tick();
    chk("t2_req5", {16'b0, imem_addr}, 32'h5);
    redir_valid = 1'b1; brSel = 2'b01; redir_pc = 16'h0005; redir_instr = 16'h00FE;
    tick();
    clear_redir();
    chk("t2_disc_req", {31'b0, imem_req}, 32'd1);
    chk("t2_disc_addr", {16'b0, imem_addr}, 32'h5);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    chk("t2_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("t2_new_addr", {16'b0, imem_addr}, 32'h4);

    // 3: backpressure fills the queue and stops requests
    instr_ready = 1'b0;
    serve(16'h4, 16'hB004);
    chk_head("t3_h4", 16'h4, 16'hB004);
    serve(16'h5, 16'hB005);
    chk("t3_full_req", {31'b0, imem_req}, 32'd0);
    tick();
    tick();
    chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
    chk_head("t3_hold", 16'h4, 16'hB004);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk_head("t3_h5", 16'h5, 16'hB005);
    chk("t3_resume_req", {31'b0, imem_req}, 32'd1);
    chk("t3_resume_addr", {16'b0, imem_addr}, 32'h6);

    // 4: BX redirect coincident with ack
    tick();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    redir_valid = 1'b1; brEx = 1'b1; brTarget = 16'h1234;
    tick();
    imem_ack = 1'b0; clear_redir();
    chk("t4_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", {16'b0, imem_addr}, 32'h1234);

    // 5: B with offset -1 at PC 0 targets 0; fetch_pc wraps FFFF -> 0
    tick();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    redir_valid = 1'b1; brSel = 2'b10; redir_pc = 16'h0000; redir_instr = 16'h07FF;
    tick();
    imem_ack = 1'b0; clear_redir();
    chk("t5_b_addr", {16'b0, imem_addr}, 32'h0);
    tick();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    redir_valid = 1'b1; brEx = 1'b1; brTarget = 16'hFFFF;
    tick();
    imem_ack = 1'b0; clear_redir();
    serve(16'hFFFF, 16'hC0FF);
    chk_head("t5_wrap", 16'hFFFF, 16'hC0FF);
    chk("t5_wrap_addr", {16'b0, imem_addr}, 32'h0);

    // BR_SEQ without BX does nothing
    redir_valid = 1'b1; brSel = 2'b11; redir_pc = 16'h0010;
    tick();
    clear_redir();
    chk_head("seq_noeff", 16'hFFFF, 16'hC0FF);
    chk("seq_noeff_addr", {16'b0, imem_addr}, 32'h0);

    // 6: reset while discarding; late acks ignored
    redir_valid = 1'b1; brSel = 2'b00; redir_pc = 16'h0100; redir_instr = 16'h0005;
    tick();
    clear_redir();
    chk("t6_disc_req", {31'b0, imem_req}, 32'd1);
    chk("t6_disc_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hEEEE;
    tick();
    chk_reset_outs("t6_rst");
    reset = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("t6_late_valid", {31'b0, instr_valid}, 32'd0);
    serve(16'h0, 16'h1111);
    chk_head("t6_first", 16'h0, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
